// File: rtl/memoria_programa_if.sv
// Bus between the fetch stage and the program memory.
//
// Purpose : groups the load stream, the fetch request and the fetch response
//           of memoria_programa into one bundle.
// Modports:
//   master - the load/fetch side: drives carga_* and leitura_req/endereco, and
//            observes the response and status outputs.
//   slave  - memoria_programa itself.
// Signals :
//   carga_inicio      start (or restart) a program load, single-cycle pulse
//   carga_valido      carga_dado holds a word to store
//   carga_dado        word written at the current load pointer
//   carga_fim         last word of the program (may coincide with carga_valido)
//   carga_pronto      memory accepts load words
//   leitura_req       fetch request
//   endereco          fetch address
//   instrucao         fetched word, registered
//   instrucao_valida  instrucao carries a response this cycle
//   fora_limite       this cycle's response addressed beyond the loaded program
//   executando        memory is in the execution state
//   tamanho           number of words in the loaded program
interface memoria_programa_if #(
  parameter int unsigned LARGURA_DADO = 8,
  parameter int unsigned LARGURA_END  = 8
) ();

  logic                    carga_inicio;
  logic                    carga_valido;
  logic [LARGURA_DADO-1:0] carga_dado;
  logic                    carga_fim;
  logic                    carga_pronto;
  logic                    leitura_req;
  logic [LARGURA_END-1:0]  endereco;
  logic [LARGURA_DADO-1:0] instrucao;
  logic                    instrucao_valida;
  logic                    fora_limite;
  logic                    executando;
  logic [LARGURA_END:0]    tamanho;

  modport master (
    output carga_inicio,
    output carga_valido,
    output carga_dado,
    output carga_fim,
    output leitura_req,
    output endereco,
    input  carga_pronto,
    input  instrucao,
    input  instrucao_valida,
    input  fora_limite,
    input  executando,
    input  tamanho
  );

  modport slave (
    input  carga_inicio,
    input  carga_valido,
    input  carga_dado,
    input  carga_fim,
    input  leitura_req,
    input  endereco,
    output carga_pronto,
    output instrucao,
    output instrucao_valida,
    output fora_limite,
    output executando,
    output tamanho
  );

endinterface

// File: rtl/memoria_programa.sv
// Loadable program memory for the fetch stage.
//
// Purpose : a clocked RAM filled at run time through a word-stream load port
//           and then served to the fetch unit through a registered read port
//           with one cycle of latency. The loaded program length is kept in
//           tamanho so fetches past the end of the program can be flagged.
// Ports   :
//   clock  - single clock, all state updates on the rising edge
//   reset  - asynchronous, active-high; clears control state and outputs,
//            array contents are kept
//   bus    - memoria_programa_if.slave: load stream, fetch request/response,
//            status (carga_pronto, executando, tamanho)
// Options :
//   MEMORIA_LIMITE_EN - when defined, reads at endereco >= tamanho return 0
//                       with fora_limite=1; when undefined there is no bound
//                       comparator and fora_limite is tied to 0.
module memoria_programa #(
  parameter int unsigned LARGURA_DADO = 8,
  parameter int unsigned LARGURA_END  = 8
) (
  input logic               clock,
  input logic               reset,
  memoria_programa_if.slave bus
);

  localparam int unsigned Profundidade = 2 ** LARGURA_END;

  typedef enum logic [1:0] {
    StOcioso   = 2'd0,
    StCarga    = 2'd1,
    StExecucao = 2'd2
  } estado_e;

  // Storage: no reset, contents survive reset and reloads.
  logic [LARGURA_DADO-1:0] r_mem [Profundidade];

  estado_e                 r_estado_q, w_estado_d;
  logic [LARGURA_END:0]    r_tamanho_q, w_tamanho_d;
  logic [LARGURA_DADO-1:0] r_instrucao_q;
  logic                    r_valida_q;
  logic                    r_fora_q;

  logic                    w_escreve;
  logic [LARGURA_END-1:0]  w_ponteiro;
  logic                    w_ultimo;
  logic                    w_leitura;
  logic                    w_fora;
  logic [LARGURA_DADO-1:0] w_dado_lido;

  // While loading, tamanho never exceeds Profundidade-1, so its low bits are
  // the load pointer; no separate pointer register is needed.
  assign w_ponteiro = r_tamanho_q[LARGURA_END-1:0];
  assign w_ultimo   = (w_ponteiro == {LARGURA_END{1'b1}});

  // Next-state and load control.
  always_comb begin
    w_estado_d  = r_estado_q;
    w_tamanho_d = r_tamanho_q;
    w_escreve   = 1'b0;

    unique case (r_estado_q)
      StOcioso: begin
        if (bus.carga_inicio) begin
          w_estado_d  = StCarga;
          w_tamanho_d = '0;
        end
      end

      StCarga: begin
        if (bus.carga_inicio) begin
          // Restart: any word presented in the same cycle is discarded.
          w_tamanho_d = '0;
        end else begin
          if (bus.carga_valido) begin
            w_escreve   = 1'b1;
            w_tamanho_d = r_tamanho_q + {{LARGURA_END{1'b0}}, 1'b1};
            // Filling the last address ends the load; no wrap-around.
            if (w_ultimo) begin
              w_estado_d = StExecucao;
            end
          end
          if (bus.carga_fim) begin
            w_estado_d = StExecucao;
          end
        end
      end

      StExecucao: begin
        if (bus.carga_inicio) begin
          w_estado_d  = StCarga;
          w_tamanho_d = '0;
        end
      end

      default: begin
        w_estado_d  = StOcioso;
        w_tamanho_d = '0;
      end
    endcase
  end

  // A read issued together with carga_inicio is dropped.
  assign w_leitura = (r_estado_q == StExecucao) && bus.leitura_req && !bus.carga_inicio;

`ifdef MEMORIA_LIMITE_EN
  always_comb begin
    w_fora      = ({1'b0, bus.endereco} >= r_tamanho_q);
    w_dado_lido = w_fora ? '0 : r_mem[bus.endereco];
  end
`else
  always_comb begin
    w_fora      = 1'b0;
    w_dado_lido = r_mem[bus.endereco];
  end
`endif

  // Control state and registered read response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado_q    <= StOcioso;
      r_tamanho_q   <= '0;
      r_instrucao_q <= '0;
      r_valida_q    <= 1'b0;
      r_fora_q      <= 1'b0;
    end else begin
      r_estado_q  <= w_estado_d;
      r_tamanho_q <= w_tamanho_d;
      r_valida_q  <= w_leitura;
      r_fora_q    <= w_leitura & w_fora;
      // Without a request the last fetched word is held.
      if (w_leitura) begin
        r_instrucao_q <= w_dado_lido;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_escreve) begin
      r_mem[w_ponteiro] <= bus.carga_dado;
    end
  end

  assign bus.carga_pronto     = (r_estado_q == StCarga);
  assign bus.executando       = (r_estado_q == StExecucao);
  assign bus.tamanho          = r_tamanho_q;
  assign bus.instrucao        = r_instrucao_q;
  assign bus.instrucao_valida = r_valida_q;
  assign bus.fora_limite      = r_fora_q;

endmodule

// File: tb/tb_memoria_programa.sv
// Self-checking bench for memoria_programa (LARGURA_END=4, LARGURA_DADO=8).
// Read responses are checked through a scoreboard queue: the expected record
// is pushed when the request is driven and popped when the response is due.
module tb_memoria_programa;

  localparam int unsigned LarguraDado = 8;
  localparam int unsigned LarguraEnd  = 4;

`ifdef MEMORIA_LIMITE_EN
  localparam bit LimiteEn = 1'b1;
`else
  localparam bit LimiteEn = 1'b0;
`endif

  typedef struct {
    logic [LarguraEnd-1:0]  addr;
    logic [LarguraDado-1:0] instr;
    logic                   fora;
    logic                   confere_instr;
  } vetor_t;

  logic clock = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  vetor_t fila[$];
  vetor_t tab_a[5];
  vetor_t tab_b[3];

  always #5 clock = ~clock;

  memoria_programa_if #(
    .LARGURA_DADO(LarguraDado),
    .LARGURA_END (LarguraEnd)
  ) bus_if ();

  memoria_programa #(
    .LARGURA_DADO(LarguraDado),
    .LARGURA_END (LarguraEnd)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  task automatic check(input string nome, input logic [31:0] atual,
                       input logic [31:0] requerido);
    n_checks++;
    if (atual !== requerido) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, atual, requerido);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_status(input string nome, input logic pronto, input logic exec,
                              input int tam);
    check({nome, " carga_pronto"}, 32'(bus_if.carga_pronto), 32'(pronto));
    check({nome, " executando"}, 32'(bus_if.executando), 32'(exec));
    check({nome, " tamanho"}, 32'(bus_if.tamanho), 32'(tam));
  endtask

  // Drives one fetch; leitura_req is left high so calls can be back to back.
  task automatic ler(input vetor_t v);
    vetor_t e;
    bus_if.leitura_req = 1'b1;
    bus_if.endereco    = v.addr;
    fila.push_back(v);
    tick();
    e = fila.pop_front();
    check($sformatf("leitura[%0d] valida", e.addr), 32'(bus_if.instrucao_valida), 32'd1);
    check($sformatf("leitura[%0d] fora_limite", e.addr), 32'(bus_if.fora_limite),
          32'(e.fora));
    if (e.confere_instr) begin
      check($sformatf("leitura[%0d] instrucao", e.addr), 32'(bus_if.instrucao),
            32'(e.instr));
    end
  endtask

  task automatic carrega(input logic [LarguraDado-1:0] dado, input logic fim);
    bus_if.carga_valido = 1'b1;
    bus_if.carga_dado   = dado;
    bus_if.carga_fim    = fim;
    tick();
    bus_if.carga_valido = 1'b0;
    bus_if.carga_fim    = 1'b0;
  endtask

  task automatic pulso_inicio();
    bus_if.carga_inicio = 1'b1;
    tick();
    bus_if.carga_inicio = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vetor_t v;

    tab_a[0] = '{4'd0, 8'hB0, 1'b0, 1'b1};
    tab_a[1] = '{4'd1, 8'hB5, 1'b0, 1'b1};
    tab_a[2] = '{4'd2, 8'hBA, 1'b0, 1'b1};
    tab_a[3] = '{4'd3, 8'h00, LimiteEn, LimiteEn};
    tab_a[4] = '{4'd1, 8'hB5, 1'b0, 1'b1};

    tab_b[0] = '{4'd0, 8'h10, 1'b0, 1'b1};
    tab_b[1] = '{4'd15, 8'h1F, 1'b0, 1'b1};
    tab_b[2] = '{4'd8, 8'h18, 1'b0, 1'b1};

    reset               = 1'b1;
    bus_if.carga_inicio = 1'b0;
    bus_if.carga_valido = 1'b0;
    bus_if.carga_dado   = '0;
    bus_if.carga_fim    = 1'b0;
    bus_if.leitura_req  = 1'b0;
    bus_if.endereco     = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state, then a read in OCIOSO is ignored.
    check_status("reset", 1'b0, 1'b0, 0);
    check("reset instrucao", 32'(bus_if.instrucao), 32'h0);
    check("reset valida", 32'(bus_if.instrucao_valida), 32'd0);
    check("reset fora_limite", 32'(bus_if.fora_limite), 32'd0);
    bus_if.leitura_req = 1'b1;
    tick();
    bus_if.leitura_req = 1'b0;
    check("ocioso leitura valida", 32'(bus_if.instrucao_valida), 32'd0);
    check("ocioso leitura instrucao", 32'(bus_if.instrucao), 32'h0);
    check_status("ocioso leitura", 1'b0, 1'b0, 0);

    // Three-word program, carga_fim on the last word.
    pulso_inicio();
    check_status("inicio", 1'b1, 1'b0, 0);
    carrega(8'hB0, 1'b0);
    carrega(8'hB5, 1'b0);
    check_status("carga 2 palavras", 1'b1, 1'b0, 2);
    carrega(8'hBA, 1'b1);
    check_status("carga fim", 1'b0, 1'b1, 3);

    for (int i = 0; i < 5; i++) begin
      ler(tab_a[i]);
    end
    bus_if.leitura_req = 1'b0;
    tick();
    check("sem req valida", 32'(bus_if.instrucao_valida), 32'd0);
    check("sem req mantem instrucao", 32'(bus_if.instrucao), 32'hB5);
    check("sem req fora_limite", 32'(bus_if.fora_limite), 32'd0);

    // Overflow: 20 words into a 16-word array.
    pulso_inicio();
    for (int i = 0; i < 20; i++) begin
      carrega(8'(8'h10 + i), 1'b0);
      if (i == 14) check_status("carga 15 palavras", 1'b1, 1'b0, 15);
      if (i == 15) check_status("carga cheia", 1'b0, 1'b1, 16);
    end
    check_status("carga excedente ignorada", 1'b0, 1'b1, 16);
    for (int i = 0; i < 3; i++) begin
      ler(tab_b[i]);
    end
    bus_if.leitura_req = 1'b0;

    // Reset mid-load, then a one-word reload.
    pulso_inicio();
    carrega(8'h77, 1'b0);
    carrega(8'h78, 1'b0);
    reset = 1'b1;
    #1;
    check_status("reset assincrono", 1'b0, 1'b0, 0);
    reset = 1'b0;
    pulso_inicio();
    carrega(8'h43, 1'b1);
    check_status("recarga", 1'b0, 1'b1, 1);
    v = '{4'd0, 8'h43, 1'b0, 1'b1};
    ler(v);
    // Address 1 still holds 0x78 from the interrupted load.
    v = '{4'd1, LimiteEn ? 8'h00 : 8'h78, LimiteEn, 1'b1};
    ler(v);
    bus_if.leitura_req = 1'b0;

    // carga_inicio together with a read: the read is dropped.
    bus_if.carga_inicio = 1'b1;
    bus_if.leitura_req  = 1'b1;
    bus_if.endereco     = 4'd0;
    tick();
    bus_if.carga_inicio = 1'b0;
    bus_if.leitura_req  = 1'b0;
    check("inicio+leitura valida", 32'(bus_if.instrucao_valida), 32'd0);
    check_status("inicio+leitura", 1'b1, 1'b0, 0);

    // carga_fim with no words: empty program.
    bus_if.carga_fim = 1'b1;
    tick();
    bus_if.carga_fim = 1'b0;
    check_status("programa vazio", 1'b0, 1'b1, 0);
    v = '{4'd0, LimiteEn ? 8'h00 : 8'h43, LimiteEn, 1'b1};
    ler(v);

    // Reset during a pending read: no response.
    bus_if.endereco = 4'd0;
    #2;
    reset = 1'b1;
    #1;
    check("reset leitura valida", 32'(bus_if.instrucao_valida), 32'd0);
    reset = 1'b0;
    tick();
    bus_if.leitura_req = 1'b0;
    check("pos reset leitura valida", 32'(bus_if.instrucao_valida), 32'd0);
    check_status("pos reset leitura", 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
